phase_generator: RTL and testbench
==================================

# phase_generator

Parametrised multi-phase clock-enable generator for the 8-bit computer. It derives NUM_PH phase signals from clock_50: phi[0] is the slowest (CPU) phase, and each higher index runs at twice the rate of the one below it (memory and video phases). It adds what the fixed divider lacks: a runtime-programmable period, reset, per-phase edge strobes, and run/halt/single-step control for debug.

## Interface
Parameters:
- DIV_WIDTH, 8: width of the half-period input and the internal counter.
- NUM_PH, 3: number of phase outputs, minimum 1.
- DEFAULT_HALF, 40: half-period loaded on reset.

Ports:
- clock_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- half_period  in  DIV_WIDTH  requested phi[0] half-period, in clock_50 cycles.
- run  in  1  level: 1 = free-run, 0 = halt at the next frame end.
- step  in  1  one-cycle pulse: while halted, run exactly one frame.
- phi  out  NUM_PH  phase outputs.
- phi_edge  out  NUM_PH  one-cycle strobe in the first cycle after phi[k] changes.
- frame_tick  out  1  one-cycle strobe in the first cycle after a frame end.
- halted  out  1  high while in HALT.

## Operation
- Effective half-period: H_eff = max(H, 2^(NUM_PH-1)) with the low NUM_PH-1 bits cleared. H is the latched half_period.
  - Examples for NUM_PH=3: H=5 gives 4; H=0 gives 4; H=41 gives 40.
- Latching of H:
  - Reset loads DEFAULT_HALF.
  - H is re-sampled at every frame end.
  - H is re-sampled every cycle while in HALT.
  - A mid-frame change to half_period never affects the current frame.
- Counter c runs 0..H_eff-1 and increments once per cycle in RUN and STEP.
- Frame end occurs when c == H_eff-1. On that edge:
  - c returns to 0.
  - Every phi[k] toggles.
  - frame_tick is asserted.
- Other cycles: phi[k] for k>0 also toggles when (c+1) is a multiple of (H_eff >> k).
  - phi[k] therefore toggles every H_eff>>k cycles.
- phi_edge[k] is registered and asserted in the same cycle that phi[k] first shows its new value.
- State machine, with HALT as the reset state:
  - HALT:
    - run=1 goes to RUN.
    - Otherwise step=1 goes to STEP.
    - Otherwise stay in HALT.
    - c holds 0; phi holds; no strobes.
  - RUN: at frame end, run=0 goes to HALT; otherwise stay in RUN. run is ignored mid-frame. step is ignored.
  - STEP: at frame end, run=1 goes to RUN, else to HALT. step is ignored mid-step.
- run and step both high in HALT: run wins.
- Reset mid-operation takes effect immediately and asynchronously. All state returns to reset values; any partial frame is discarded.

## Timing
- Reset values:
  - phi[0]=0; phi[k>0]=1.
  - phi_edge=0, frame_tick=0.
  - halted=1, c=0, state=HALT, H=DEFAULT_HALF.
- Start from HALT with run=1:
  - Edge 1 enters RUN; halted drops after edge 1.
  - Edge 1+H_eff is the first frame end.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency from step pulse to first phi change is the same as for run: 1+(H_eff>>(NUM_PH-1)) edges, with H_eff including any change sampled while halted.
- Halt request:
  - run deasserted mid-frame: phi keeps running to frame end, then halts.
  - halted rises with the final toggle.
- Duty cycle is 50% on every phase; phases are edge-aligned at every frame end.

## Test plan
- Default params, run=1 after reset, half_period=40 held:
  - phi[2] toggles every 10 cycles, phi[1] every 20, phi[0] every 40.
  - First phi[2] toggle on edge 11.
  - phi_edge pulses are exactly 1 cycle wide; frame_tick every 40 cycles.
- Clamp and rounding: half_period=5 gives 4-cycle frames. half_period=0 gives 4. half_period=41 gives 40, with phi[2] toggling every 10.
- Mid-frame change: half_period 40→16 at c=7. The current frame still lasts 40 cycles; the next frame lasts 16 (phi[2] every 4).
- Halt/step: run falls at c=12. Frame completes at c=39, then halted=1 and phi is frozen. A step pulse gives exactly one 40-cycle frame, then HALT again; exactly one frame_tick.
- run and step together in HALT: RUN is entered and continues past the frame end; halted=0.
- Asynchronous reset asserted at c=25 between clock edges: outputs return to reset values immediately. After release with run=1, the first phi[2] toggle is on edge 11.

Source files
------------

// File: rtl/phase_generator.sv
// phase_generator: multi-phase clock-enable generator driven from clock_50.
// phi[0] is the slowest phase; each higher index runs at twice the rate of
// the one below it. All phases are edge-aligned at every frame end.
// The period is programmable at runtime, and run/halt/single-step control
// is provided for debug.
module phase_generator #(
   parameter int DIV_WIDTH    = 8,
   parameter int NUM_PH       = 3,
   parameter int DEFAULT_HALF = 40
) (
   input  logic                 clock_50,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] half_period,
   input  logic                 run,
   input  logic                 step,
   output logic [NUM_PH-1:0]    phi,
   output logic [NUM_PH-1:0]    phi_edge,
   output logic                 frame_tick,
   output logic                 halted
);

   localparam logic [DIV_WIDTH-1:0] LP_ONE     = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] LP_MIN     = LP_ONE << (NUM_PH - 1);
   localparam logic [DIV_WIDTH-1:0] LP_MASK    = ~(LP_MIN - LP_ONE);
   localparam logic [DIV_WIDTH-1:0] LP_DEFAULT = DIV_WIDTH'(DEFAULT_HALF);
   localparam logic [NUM_PH-1:0]    LP_PHI_RST = ~(NUM_PH'(1));

   typedef enum logic [1:0] {
      ST_HALT,
      ST_RUN,
      ST_STEP
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // latched half-period and its clamped/rounded effective value
   logic [DIV_WIDTH-1:0] r_h;
   logic [DIV_WIDTH-1:0] w_heff;

   // per-phase toggle period and sub-counters; r_sub[0] is the frame counter
   logic [DIV_WIDTH-1:0] w_per      [NUM_PH];
   logic [DIV_WIDTH-1:0] r_sub      [NUM_PH];
   logic [DIV_WIDTH-1:0] w_sub_next [NUM_PH];

   logic                 w_active;
   logic                 w_frame_end;
   logic [NUM_PH-1:0]    w_toggle;

   // registered outputs
   logic [NUM_PH-1:0]    r_phi;
   logic [NUM_PH-1:0]    r_phi_edge;
   logic                 r_frame_tick;
   logic                 r_halted;

   logic [NUM_PH-1:0]    w_phi_next;
   logic [NUM_PH-1:0]    w_phi_edge_next;
   logic                 w_frame_tick_next;
   logic                 w_halted_next;

   // effective half-period: at least 2^(NUM_PH-1), low NUM_PH-1 bits cleared
   always_comb begin
      if (r_h < LP_MIN) begin
         w_heff = LP_MIN;
      end else begin
         w_heff = r_h & LP_MASK;
      end
   end

   // toggle period of each phase; exact divisors of w_heff by construction
   always_comb begin
      for (int unsigned k = 0; k < NUM_PH; k++) begin
         w_per[k] = w_heff >> k;
      end
   end

   assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_frame_end = w_active && (r_sub[0] == (w_heff - LP_ONE));

   // per-phase toggle decision and sub-counter advance
   always_comb begin
      w_toggle = '0;
      for (int unsigned k = 0; k < NUM_PH; k++) begin
         w_sub_next[k] = '0;
         if (w_active) begin
            if (w_frame_end || (r_sub[k] == (w_per[k] - LP_ONE))) begin
               w_toggle[k]   = 1'b1;
               w_sub_next[k] = '0;
            end else begin
               w_sub_next[k] = r_sub[k] + LP_ONE;
            end
         end
      end
   end

   // state register
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_state <= ST_HALT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state logic: run wins over step in HALT; decisions only at frame end
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_HALT: begin
            if (run) begin
               w_next_state = ST_RUN;
            end else if (step) begin
               w_next_state = ST_STEP;
            end
         end
         ST_RUN: begin
            if (w_frame_end && !run) begin
               w_next_state = ST_HALT;
            end
         end
         ST_STEP: begin
            if (w_frame_end) begin
               w_next_state = run ? ST_RUN : ST_HALT;
            end
         end
         default: w_next_state = ST_HALT;
      endcase
   end

   // output logic: next values for the registered outputs
   always_comb begin
      w_phi_next        = r_phi ^ w_toggle;
      w_phi_edge_next   = w_toggle;
      w_frame_tick_next = w_frame_end;
      w_halted_next     = (w_next_state == ST_HALT);
   end

   // half-period latch: sampled every cycle in HALT and at each frame end only
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_h <= LP_DEFAULT;
      end else if ((r_state == ST_HALT) || w_frame_end) begin
         r_h <= half_period;
      end
   end

   // frame counter and per-phase sub-counters
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_PH; k++) begin
            r_sub[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_PH; k++) begin
            r_sub[k] <= w_sub_next[k];
         end
      end
   end

   // output registers
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_phi        <= LP_PHI_RST;
         r_phi_edge   <= '0;
         r_frame_tick <= 1'b0;
         r_halted     <= 1'b1;
      end else begin
         r_phi        <= w_phi_next;
         r_phi_edge   <= w_phi_edge_next;
         r_frame_tick <= w_frame_tick_next;
         r_halted     <= w_halted_next;
      end
   end

   assign phi        = r_phi;
   assign phi_edge   = r_phi_edge;
   assign frame_tick = r_frame_tick;
   assign halted     = r_halted;

endmodule

// File: tb/tb_phase_generator.sv
// Scoreboard bench for phase_generator (NUM_PH=3, DIV_WIDTH=8, DEFAULT_HALF=40).
// Stimulus pushes the expected strobe events (edge number, phi, phi_edge,
// frame_tick, halted); the monitor pops one for every cycle with a strobe.
module tb_phase_generator;

   logic       clk;
   logic       reset;
   logic [7:0] half_period;
   logic       run;
   logic       step;
   logic [2:0] phi;
   logic [2:0] phi_edge;
   logic       frame_tick;
   logic       halted;

   typedef struct {
      int         e;
      logic [2:0] phi;
      logic [2:0] pe;
      logic       ft;
      logic       hl;
   } ev_t;

   ev_t        sb[$];
   ev_t        mon_ev;
   int         edge_n = 0;
   int         checks = 0;
   int         errors = 0;
   int         t;
   logic [2:0] m_phi;

   phase_generator #(
      .DIV_WIDTH   (8),
      .NUM_PH      (3),
      .DEFAULT_HALF(40)
   ) dut (
      .clock_50   (clk),
      .reset      (reset),
      .half_period(half_period),
      .run        (run),
      .step       (step),
      .phi        (phi),
      .phi_edge   (phi_edge),
      .frame_tick (frame_tick),
      .halted     (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_n++;

   // monitor: every strobe cycle must match the next queued expectation
   always @(negedge clk) begin
      if ((phi_edge != 3'b000) || frame_tick) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event edge=%0d phi=%b phi_edge=%b frame_tick=%b halted=%b",
                     edge_n, phi, phi_edge, frame_tick, halted);
         end else begin
            mon_ev = sb.pop_front();
            if ((mon_ev.e != edge_n) || (phi !== mon_ev.phi) || (phi_edge !== mon_ev.pe) ||
                (frame_tick !== mon_ev.ft) || (halted !== mon_ev.hl)) begin
               errors++;
               $display("FAIL event got edge=%0d phi=%b pe=%b ft=%b hl=%b want edge=%0d phi=%b pe=%b ft=%b hl=%b",
                        edge_n, phi, phi_edge, frame_tick, halted,
                        mon_ev.e, mon_ev.phi, mon_ev.pe, mon_ev.ft, mon_ev.hl);
            end
         end
      end
   end

   task automatic wait_edge(input int n);
      while (edge_n < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   // queue nev strobe events of a heff-cycle frame starting after edge t;
   // within a frame: phi[2] every heff/4, phi[1] every heff/2, phi[0] at end
   task automatic push_ev(input int heff, input int nev, input bit halt_last);
      int   q;
      int   j;
      ev_t  ev;
      q = heff / 4;
      for (int i = 1; i <= nev; i++) begin
         j     = ((i - 1) % 4) + 1;
         ev.e  = t + i * q;
         ev.pe = {1'b1, (j % 2 == 0), (j == 4)};
         m_phi = m_phi ^ ev.pe;
         ev.phi = m_phi;
         ev.ft = (j == 4);
         ev.hl = halt_last && (i == nev);
         sb.push_back(ev);
      end
      t = t + nev * q;
   endtask

   task automatic drain(input string nm, input int limit);
      while ((sb.size() != 0) && (edge_n < limit)) begin
         @(posedge clk);
         #1;
      end
      chk(nm, sb.size(), 0);
   endtask

   initial begin
      reset       = 1'b0;
      run         = 1'b0;
      step        = 1'b0;
      half_period = 8'd40;
      m_phi       = 3'b110;
      #1 reset = 1'b1;
      #1;
      chk("rst_phi", int'(phi), 6);
      chk("rst_phi_edge", int'(phi_edge), 0);
      chk("rst_frame_tick", int'(frame_tick), 0);
      chk("rst_halted", int'(halted), 1);
      wait_edge(3);
      reset = 1'b0;

      // free run with H=40, then mid-frame change to 16, clamps 5/0, rounding 41
      wait_edge(8);
      run = 1'b1;
      t   = 9;
      push_ev(40, 12, 1'b0);
      push_ev(16, 8, 1'b0);
      push_ev(4, 8, 1'b0);
      push_ev(40, 4, 1'b0);
      push_ev(40, 4, 1'b1);
      wait_edge(10);
      chk("halted_drop", int'(halted), 0);
      wait_edge(96);
      half_period = 8'd16;
      wait_edge(150);
      half_period = 8'd5;
      wait_edge(162);
      half_period = 8'd0;
      wait_edge(166);
      half_period = 8'd41;
      wait_edge(180);
      half_period = 8'd40;
      wait_edge(221);
      run = 1'b0;
      drain("drain_run", 260);
      wait_edge(270);
      chk("halt_halted", int'(halted), 1);
      chk("halt_phi_frozen", int'(phi), int'(m_phi));

      // single step with a period changed while halted; second step ignored
      wait_edge(275);
      half_period = 8'd16;
      wait_edge(280);
      step = 1'b1;
      t    = 281;
      push_ev(16, 4, 1'b1);
      wait_edge(281);
      step = 1'b0;
      wait_edge(286);
      step = 1'b1;
      wait_edge(287);
      step = 1'b0;
      wait_edge(300);
      half_period = 8'd40;
      drain("drain_step", 320);
      wait_edge(380);
      chk("step_halted", int'(halted), 1);
      chk("step_phi_frozen", int'(phi), int'(m_phi));

      // run and step together: RUN wins and continues past frame end
      wait_edge(390);
      run  = 1'b1;
      step = 1'b1;
      t    = 391;
      push_ev(40, 10, 1'b0);
      wait_edge(391);
      step = 1'b0;
      wait_edge(475);
      chk("runstep_halted", int'(halted), 0);

      // asynchronous reset at c=25 of the third frame
      wait_edge(496);
      #3 reset = 1'b1;
      #1;
      chk("arst_phi", int'(phi), 6);
      chk("arst_phi_edge", int'(phi_edge), 0);
      chk("arst_frame_tick", int'(frame_tick), 0);
      chk("arst_halted", int'(halted), 1);
      chk("arst_queue", sb.size(), 0);
      m_phi = 3'b110;
      wait_edge(500);
      reset = 1'b0;
      t     = 501;
      push_ev(40, 4, 1'b1);
      wait_edge(506);
      run = 1'b0;
      drain("drain_arst", 560);
      wait_edge(570);
      chk("final_halted", int'(halted), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
